nibble_add_seq: RTL and testbench

- Multi-nibble add/subtract sequencer that drives one external 4-bit ripple-carry adder stage, one nibble per clock, LSB nibble first.
- Latches wide operands and feeds the adder's a/b/cin inputs. Consumes the adder's sum/cout, chains the carry through a register, and assembles the wide result.
- Sits directly upstream and downstream of the 4-bit adder, between a valid/ready producer and consumer.

---
 rtl/nibble_add_seq.sv | 145 ++++++++++++++
 tb/tb_nibble_add_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_add_seq.sv
// -----------------------------------------------------------------------------
// nibble_add_seq
//
// Multi-nibble add/subtract sequencer wrapped around one external 4-bit
// ripple-carry adder stage. A wide request (op_a, op_b, op_cin, op_sub) is
// accepted over a valid/ready handshake and latched. One nibble per clock is
// then presented to the adder, LSB nibble first. The adder's sum is written
// into the wide result, and its carry is chained through a register into the
// next nibble. When the MSB nibble completes, the result is presented to the
// consumer over a second valid/ready handshake.
//
// Subtraction is A + ~B + 1. B is inverted when it is latched, and the carry
// register is seeded with 1, so the adder always performs a plain add.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (accepted only in IDLE)
//   op_a, op_b           W-bit operands, sampled on the accepting edge
//   op_cin               carry-in for add (ignored when op_sub=1)
//   op_sub               1 = compute op_a - op_b
//   out_valid/out_ready  result handshake
//   result               W-bit sum/difference, held until overwritten
//   result_cout          carry out of MSB nibble (subtract: 1 = no borrow)
//   result_ovf           signed overflow
//   add_a, add_b, add_cin   drive the external 4-bit adder (zero outside RUN)
//   add_sum, add_cout       from the external adder (used only in RUN)
// -----------------------------------------------------------------------------
module nibble_add_seq #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  input  logic         op_sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         result_cout,
  output logic         result_ovf,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  localparam int CW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_q;      // latched operand A
  logic [W-1:0]    b_q;      // latched operand B, pre-inverted for subtract
  logic            carry_q;  // carry into the nibble currently presented
  logic [CW-1:0]   cnt_q;    // index of the nibble currently presented
  logic [CW+1:0]   nib_idx;  // bit offset of that nibble (4*cnt_q)
  logic            last_nib;

  assign nib_idx  = {cnt_q, 2'b00};
  assign last_nib = (cnt_q == CW'(NIBBLES - 1));

  // NOTE: every signal assigned in this block gets a default before the
  // case logic, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == S_RUN) begin
      add_a   = a_q[nib_idx +: 4];
      add_b   = b_q[nib_idx +: 4];
      add_cin = carry_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      result_cout <= 1'b0;
      result_ovf  <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= op_a;
            b_q      <= op_b ^ {W{op_sub}};
            // Subtract seeds the +1 of the two's complement here.
            carry_q  <= op_sub | op_cin;
            cnt_q    <= '0;
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end

        S_RUN: begin
          // The adder is combinational, so its sum for this nibble is
          // already settled and is captured on this edge.
          result[nib_idx +: 4] <= add_sum;
          carry_q              <= add_cout;
          if (last_nib) begin
            result_cout <= add_cout;
            // Overflow: operands share a sign that the result does not.
            result_ovf  <= (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// -----------------------------------------------------------------------------
// tb_nibble_add_seq
//
// Self-checking bench for nibble_add_seq (NIBBLES=4) with a reference 4-bit
// combinational adder attached. A behavioural model computes each whole-word
// result with plain wide arithmetic and tracks handshake/latency timing. A
// compare process checks the DUT against the model on every falling edge.
// Directed tests also pin the model with hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_nibble_add_seq;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         result_cout;
  logic         result_ovf;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  int n_checks = 0;
  int n_fail   = 0;

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout), .result_ovf(result_ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  // Reference 4-bit ripple-carry adder stage.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'h0, add_cin};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_ready, m_valid;
  int           m_cnt;                 // RUN cycles still to go (0 = not running)
  logic [W-1:0] m_result, m_a, m_bp, e_result;
  logic         m_cout, m_ovf, m_c0, e_cout, e_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready = 1'b1; m_valid = 1'b0; m_cnt = 0;
      m_result = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1; m_result = e_result; m_cout = e_cout; m_ovf = e_ovf;
      end
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid = 1'b0; m_ready = 1'b1;
      end
    end else if (in_valid) begin
      logic [W:0] full;
      int sa, sb, ss;
      m_a  = op_a;
      m_bp = op_sub ? ~op_b : op_b;
      m_c0 = op_sub ? 1'b1 : op_cin;
      full = {1'b0, m_a} + {1'b0, m_bp} + {{W{1'b0}}, m_c0};
      sa = $signed(op_a);
      sb = $signed(op_b);
      ss = op_sub ? sa - sb : sa + sb + int'(op_cin);
      e_result = full[W-1:0];
      e_cout   = full[W];
      e_ovf    = (ss > (2 ** (W - 1)) - 1) || (ss < -(2 ** (W - 1)));
      m_cnt    = NIBBLES;
      m_ready  = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    check("in_ready", in_ready, m_ready);
    check("out_valid", out_valid, m_valid);
    if (m_cnt == 0) begin
      check("result", result, m_result);
      check("result_cout", result_cout, m_cout);
      check("result_ovf", result_ovf, m_ovf);
      check("add_a_idle", add_a, 0);
      check("add_b_idle", add_b, 0);
      check("add_cin_idle", add_cin, 0);
    end else begin
      int k;
      longint mask, lo;
      k    = NIBBLES - m_cnt;
      mask = (longint'(1) << (4 * k)) - 1;
      lo   = (longint'(m_a) & mask) + (longint'(m_bp) & mask) + longint'(m_c0);
      check("add_a_run", add_a, (m_a >> (4 * k)) & 4'hF);
      check("add_b_run", add_b, (m_bp >> (4 * k)) & 4'hF);
      check("add_cin_run", add_cin, 32'((lo >> (4 * k)) & 1));
    end
  end

  // ---------------- directed stimulus ----------------
  logic [3:0] obs_a [NIBBLES];
  logic [3:0] obs_b [NIBBLES];
  logic       obs_cin [NIBBLES];

  // Called #1 after a rising edge. Issues one request, waits for the result,
  // checks it against literals, then completes the output handshake.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub,
                        input logic [W-1:0] er, input logic ec, input logic eo);
    int g, lat;
    g = 0;
    while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
    check({name, "_ready_wait"}, 32'(g < 50), 1);
    op_a = a; op_b = b; op_cin = cin; op_sub = sub; in_valid = 1'b1;
    @(posedge clk); #1;               // accepting edge
    in_valid = 1'b0;
    op_a = '1; op_b = '1; op_cin = 1'b1; op_sub = ~sub;   // must not matter now
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (lat < NIBBLES) begin
        obs_a[lat] = add_a; obs_b[lat] = add_b; obs_cin[lat] = add_cin;
      end
      @(posedge clk); #1; lat++;
    end
    check({name, "_latency"}, lat, NIBBLES);
    check({name, "_result"}, result, er);
    check({name, "_cout"}, result_cout, ec);
    check({name, "_ovf"}, result_ovf, eo);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_released"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    check("add1_a0", obs_a[0], 4); check("add1_a1", obs_a[1], 3);
    check("add1_a2", obs_a[2], 2); check("add1_a3", obs_a[3], 1);

    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("cin",  16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    run_op("povf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sneg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    check("sneg_b0", obs_b[0], 4'h8); check("sneg_b1", obs_b[1], 4'hF);
    check("sneg_b2", obs_b[2], 4'hF); check("sneg_b3", obs_b[3], 4'hF);
    check("sneg_cin0", obs_cin[0], 1);

    // Backpressure: result held while a new request waits.
    op_a = 16'h1111; op_b = 16'h2222; op_cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 16'h0100; op_b = 16'h0200;          // second request, held valid
    for (int i = 0; i < NIBBLES; i++) begin @(posedge clk); #1; end
    check("bp_valid", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_result", result, 16'h3333);
      check("bp_hold_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    check("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;                        // handshake edge -> IDLE
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1);
    @(posedge clk); #1;                        // second request accepted here
    in_valid = 1'b0;
    check("bp_accepted", in_ready, 0);
    for (int i = 0; i < NIBBLES; i++) begin @(posedge clk); #1; end
    check("bp2_valid", out_valid, 1);
    check("bp2_result", result, 16'h0300);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset in the second RUN cycle.
    op_a = 16'hFFFF; op_b = 16'h0001; op_cin = 1'b1; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_result", result, 0);
    check("arst_add_a", add_a, 0);
    check("arst_add_cin", add_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("post", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
